// File: rtl/tt_pkg.sv
// Shared types and width helpers for the truth-table scanner.
package tt_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int unsigned mask_w(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    // Never zero so the settle counter always has a legal width.
    function automatic int unsigned settle_w(input int unsigned settle_cyc);
        return (settle_cyc == 0) ? 1 : $clog2(settle_cyc + 1);
    endfunction

    localparam int unsigned N_IN_DEF       = 3;
    localparam int unsigned SETTLE_CYC_DEF = 1;
    localparam int unsigned MASK_W         = mask_w(N_IN_DEF);
    localparam int unsigned SETTLE_W       = settle_w(SETTLE_CYC_DEF);

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expire is high during the last settle cycle.
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned SETTLE_W   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt    <= SETTLE_W'(SETTLE_CYC);
            expire <= (SETTLE_CYC == 1);
        end else if (cnt != '0) begin
            cnt    <= cnt - SETTLE_W'(1);
            expire <= (cnt == SETTLE_W'(2));
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector of a combinational function and captures its minterm mask.
// Optional build macro TT_COMPARE_EN adds comparison against exp_mask.
module truth_table_scanner
    import tt_pkg::*;
#(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      s_in,
    input  logic [mask_w(N_IN)-1:0]   exp_mask,
    output logic [N_IN-1:0]           vec_out,
    output logic                      busy,
    output logic                      done,
    output logic [mask_w(N_IN)-1:0]   minterm_mask,
    output logic                      mismatch,
    output logic [N_IN-1:0]           first_fail
);

    localparam int unsigned MW = mask_w(N_IN);
    localparam int unsigned SW = settle_w(SETTLE_CYC);

    state_t          state, state_nx;
    logic [N_IN-1:0] idx, idx_nx;
    logic [N_IN-1:0] vec_nx;
    logic [MW-1:0]   mask_nx;
    logic            busy_nx, done_nx;
    logic            last, accept, capture;
    logic            load, expire;

    assign last    = (idx == {N_IN{1'b1}});
    assign accept  = (state == IDLE) && start;
    assign capture = (state == SAMPLE) && !abort;
    assign load    = (state == DRIVE);

    generate
        if (SETTLE_CYC == 0) begin : g_no_settle
            logic unused_load;
            assign unused_load = load;
            assign expire      = 1'b1;
        end else begin : g_settle
            tt_settle_timer #(
                .SETTLE_CYC (SETTLE_CYC),
                .SETTLE_W   (SW)
            ) u_timer (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load),
                .expire (expire)
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; abort overrides everything except a start in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   state_nx = abort ? IDLE : ((SETTLE_CYC == 0) ? SAMPLE : SETTLE);
            SETTLE:  if (abort) state_nx = IDLE; else if (expire) state_nx = SAMPLE;
            SAMPLE:  state_nx = abort ? IDLE : (last ? DONE : DRIVE);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        idx_nx  = idx;
        mask_nx = minterm_mask;
        vec_nx  = vec_out;
        busy_nx = (state_nx == DRIVE) || (state_nx == SETTLE) || (state_nx == SAMPLE);
        done_nx = (state_nx == DONE);
        if (accept) begin
            idx_nx  = '0;
            mask_nx = '0;
        end
        if (capture) begin
            mask_nx[idx] = s_in;
            if (!last) idx_nx = idx + N_IN'(1);
        end
        if (state_nx == DRIVE) vec_nx = idx_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            minterm_mask <= '0;
        end else begin
            idx          <= idx_nx;
            vec_out      <= vec_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            minterm_mask <= mask_nx;
        end
    end

`ifdef TT_COMPARE_EN
    logic            mm_nx;
    logic [N_IN-1:0] ff_nx;

    // Only the first differing vector is recorded
    always_comb begin
        mm_nx = mismatch;
        ff_nx = first_fail;
        if (accept) begin
            mm_nx = 1'b0;
            ff_nx = '0;
        end else if (capture && (s_in != exp_mask[idx]) && !mismatch) begin
            mm_nx = 1'b1;
            ff_nx = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch   <= 1'b0;
            first_fail <= '0;
        end else begin
            mismatch   <= mm_nx;
            first_fail <= ff_nx;
        end
    end
`else
    logic unused_exp;
    assign unused_exp = ^exp_mask;
    assign mismatch   = 1'b0;
    assign first_fail = '0;
`endif

endmodule
